// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg: mode encoding and reset mode shared by the flip-flop bank files
package ff_bank_pkg;
    typedef enum logic [1:0] {
        FF_D  = 2'b00,
        FF_T  = 2'b01,
        FF_SR = 2'b10,
        FF_JK = 2'b11
    } ff_mode_t;
    localparam ff_mode_t FF_MODE_RST = FF_D;
endpackage

// File: rtl/ff_bit_next.sv
// ff_bit_next: single-bit next state for D/T/SR/JK behaviour; SR 11 holds, JK 11 toggles
module ff_bit_next
    import ff_bank_pkg::*;
(
    input  ff_mode_t mode_i,
    input  logic     a_i,
    input  logic     b_i,
    input  logic     q_i,
    output logic     q_d_o
);
    assign q_d_o = (mode_i == FF_D)  ? a_i :
                   (mode_i == FF_T)  ? q_i ^ a_i :
                   (a_i ^ b_i)       ? a_i :
                   (mode_i == FF_JK && a_i) ? ~q_i : q_i;
endmodule

// File: rtl/ff_bank_universal.sv
// ff_bank_universal: WIDTH-bit D/T/SR/JK register bank; FF_BANK_TOGGLE_CNT_EN builds a saturating flip counter
module ff_bank_universal
    import ff_bank_pkg::*;
#(
    parameter int                 WIDTH = 8,
    parameter logic [WIDTH-1:0]   INIT  = {WIDTH{1'b0}},
    parameter int                 CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode_wr,
    input  logic [1:0]       mode_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [1:0]       mode,
    output logic             chg,
    output logic             sr_err,
    output logic [WIDTH-1:0] sr_err_mask,
    output logic [CNT_W-1:0] toggle_cnt
);
    ff_mode_t         mode_q;
    logic [WIDTH-1:0] q_q, q_d, nxt, sr_hit, mask_q;
    logic             chg_q, err_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ff_bit_next u_next (
            .mode_i(mode_q),
            .a_i   (a[i]),
            .b_i   (b[i]),
            .q_i   (q_q[i]),
            .q_d_o (nxt[i])
        );
    end

    assign q_d    = en ? nxt : q_q;
    assign sr_hit = (en && mode_q == FF_SR) ? (a & b) : '0;

    // State, mode and sticky error update; a fresh error outranks err_clr on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= INIT;
            mode_q <= FF_MODE_RST;
            chg_q  <= 1'b0;
            err_q  <= 1'b0;
            mask_q <= '0;
        end else begin
            q_q    <= q_d;
            chg_q  <= (q_d != q_q);
            if (mode_wr) mode_q <= ff_mode_t'(mode_in);
            err_q  <= (err_q & ~err_clr) | (|sr_hit);
            mask_q <= (err_clr ? '0 : mask_q) | sr_hit;
        end
    end

    assign Q           = q_q;
    assign Qn          = ~q_q;
    assign mode        = mode_q;
    assign chg         = chg_q;
    assign sr_err      = err_q;
    assign sr_err_mask = mask_q;

`ifdef FF_BANK_TOGGLE_CNT_EN
    localparam int PW = $clog2(WIDTH + 1);
    logic [PW-1:0]       pc;
    logic [CNT_W+PW-1:0] sum;
    logic [CNT_W-1:0]    cnt_q;

    // Number of bits flipping on this edge
    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) pc = pc + PW'(q_d[i] ^ q_q[i]);
    end

    assign sum = {{PW{1'b0}}, cnt_q} + {{CNT_W{1'b0}}, pc};

    // Saturating flip counter; clamps instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= (|sum[CNT_W+PW-1:CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    assign toggle_cnt = cnt_q;
`else
    assign toggle_cnt = '0;
`endif
endmodule

// File: tb/tb_ff_bank_universal.sv
// tb_ff_bank_universal: directed scoreboard bench for ff_bank_universal (WIDTH=8, CNT_W=4)
module tb_ff_bank_universal;
    logic       clk = 1'b0;
    logic       reset, en, mode_wr, err_clr;
    logic [1:0] mode_in;
    logic [7:0] a, b;
    logic [7:0] Q, Qn, sr_err_mask;
    logic [1:0] mode;
    logic       chg, sr_err;
    logic [3:0] toggle_cnt;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic [1:0] mode;
        logic       chg;
        logic       err;
        logic [7:0] mask;
        logic [3:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] prev_q = 8'h00;
    int         cnt_m = 0;

    ff_bank_universal #(.WIDTH(8), .INIT(8'h00), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode_wr    (mode_wr),
        .mode_in    (mode_in),
        .a          (a),
        .b          (b),
        .err_clr    (err_clr),
        .Q          (Q),
        .Qn         (Qn),
        .mode       (mode),
        .chg        (chg),
        .sr_err     (sr_err),
        .sr_err_mask(sr_err_mask),
        .toggle_cnt (toggle_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string fld, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s.%s got %h want %h", tag, fld, got, want);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic e, input logic mw, input logic [1:0] mi,
                        input logic [7:0] aa, input logic [7:0] bb, input logic ec,
                        input logic [7:0] xq, input logic [1:0] xm, input logic xc, input logic xe,
                        input logic [7:0] xmask);
        exp_t x;
        exp_t y;
        int   pc;
        reset = r; en = e; mode_wr = mw; mode_in = mi; a = aa; b = bb; err_clr = ec;
        pc = $countones(prev_q ^ xq);
        cnt_m = r ? 0 : ((cnt_m + pc > 15) ? 15 : cnt_m + pc);
        prev_q = xq;
        x.tag = tag; x.q = xq; x.mode = xm; x.chg = xc; x.err = xe; x.mask = xmask;
`ifdef FF_BANK_TOGGLE_CNT_EN
        x.cnt = 4'(cnt_m);
`else
        x.cnt = 4'h0;
`endif
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        cmp(y.tag, "Q", Q, y.q);
        cmp(y.tag, "Qn", Qn, ~y.q);
        cmp(y.tag, "mode", {6'h0, mode}, {6'h0, y.mode});
        cmp(y.tag, "chg", {7'h0, chg}, {7'h0, y.chg});
        cmp(y.tag, "sr_err", {7'h0, sr_err}, {7'h0, y.err});
        cmp(y.tag, "mask", sr_err_mask, y.mask);
        cmp(y.tag, "cnt", {4'h0, toggle_cnt}, {4'h0, y.cnt});
    endtask

    initial begin
        //   tag           rst en mw mi     a      b      ec    Q      mode   chg err mask
        step("reset",      1, 0, 0, 2'b00, 8'h00, 8'h00, 0,    8'h00, 2'b00, 0, 0, 8'h00);
        step("d_a5",       0, 1, 0, 2'b00, 8'hA5, 8'h00, 0,    8'hA5, 2'b00, 1, 0, 8'h00);
        step("d_hold",     0, 1, 0, 2'b00, 8'hA5, 8'h00, 0,    8'hA5, 2'b00, 0, 0, 8'h00);
        step("d_00",       0, 1, 0, 2'b00, 8'h00, 8'h00, 0,    8'h00, 2'b00, 1, 0, 8'h00);
        step("mw_oldmode", 0, 1, 1, 2'b01, 8'hFF, 8'h00, 0,    8'hFF, 2'b01, 1, 0, 8'h00);
        step("t_0f",       0, 1, 0, 2'b00, 8'h0F, 8'h00, 0,    8'hF0, 2'b01, 1, 0, 8'h00);
        step("mw_en0",     0, 0, 1, 2'b10, 8'hFF, 8'h00, 0,    8'hF0, 2'b10, 0, 0, 8'h00);
        step("sr_clr",     0, 1, 0, 2'b00, 8'h00, 8'hFF, 0,    8'h00, 2'b10, 1, 0, 8'h00);
        step("sr_err",     0, 1, 0, 2'b00, 8'h03, 8'h06, 0,    8'h01, 2'b10, 1, 1, 8'h02);
        step("err_clr",    0, 1, 0, 2'b00, 8'h00, 8'h00, 1,    8'h01, 2'b10, 0, 0, 8'h00);
        step("clr_vs_new", 0, 1, 0, 2'b00, 8'h80, 8'h80, 1,    8'h01, 2'b10, 0, 1, 8'h80);
        step("sr_en0",     0, 0, 0, 2'b00, 8'h01, 8'h01, 0,    8'h01, 2'b10, 0, 1, 8'h80);
        step("sr_to_jk",   0, 1, 1, 2'b11, 8'hF0, 8'h0F, 0,    8'hF0, 2'b11, 1, 1, 8'h80);
        step("jk_toggle",  0, 1, 0, 2'b00, 8'hFF, 8'hFF, 1,    8'h0F, 2'b11, 1, 0, 8'h00);
        step("jk_en0",     0, 0, 0, 2'b00, 8'hFF, 8'hFF, 0,    8'h0F, 2'b11, 0, 0, 8'h00);
        step("jk_hold",    0, 1, 1, 2'b10, 8'h00, 8'h00, 0,    8'h0F, 2'b10, 0, 0, 8'h00);
        step("sr_11",      0, 1, 0, 2'b00, 8'hFF, 8'hFF, 0,    8'h0F, 2'b10, 0, 1, 8'hFF);
        step("rst_prio",   1, 1, 1, 2'b11, 8'hFF, 8'hFF, 1,    8'h00, 2'b00, 0, 0, 8'h00);
        step("cnt_ff",     0, 1, 0, 2'b00, 8'hFF, 8'h00, 0,    8'hFF, 2'b00, 1, 0, 8'h00);
        step("cnt_00",     0, 1, 0, 2'b00, 8'h00, 8'h00, 0,    8'h00, 2'b00, 1, 0, 8'h00);
        step("cnt_sat1",   0, 1, 0, 2'b00, 8'hFF, 8'h00, 0,    8'hFF, 2'b00, 1, 0, 8'h00);
        step("cnt_sat2",   0, 1, 0, 2'b00, 8'h00, 8'h00, 0,    8'h00, 2'b00, 1, 0, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
